ets_sweep_sequencer: RTL

Automates an equivalent-time-sampling sweep on the offset sampler.
- Steps the ETS clock-generator phase word across a programmed range.
- At each phase: waits for the clock generator to settle and relock, fires one sampler run, and captures the 32-bit result into an internal result FIFO.
- Sits between the SPI register file (configuration, start/abort, FIFO readback) and the clock generator / offset sampler pair, replacing per-point software pokes of the timing-control register and run bit.

---
 rtl/picoview_pkg.sv | 29 ++
 rtl/result_fifo.sv | 76 +++++++
 rtl/ets_sweep_sequencer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/picoview_pkg.sv
// Shared definitions for the picoview sweep logic.
//   - sweep_state_e : ETS sweep sequencer state encoding
//   - REG_SWEEP_*   : SPI register numbers for the sweep control registers
//   - STATUS_*_BIT  : bit positions inside the SWEEP_STATUS register
package picoview_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_APPLY      = 3'd1,
    ST_SETTLE     = 3'd2,
    ST_TRIGGER    = 3'd3,
    ST_WAIT_START = 3'd4,
    ST_WAIT_DONE  = 3'd5,
    ST_STORE      = 3'd6,
    ST_FINISH     = 3'd7
  } sweep_state_e;

  localparam logic [7:0] REG_SWEEP_START_PHASE = 8'h20;
  localparam logic [7:0] REG_SWEEP_STEP        = 8'h21;
  localparam logic [7:0] REG_SWEEP_COUNT       = 8'h22;
  localparam logic [7:0] REG_SWEEP_FIFO        = 8'h23;
  localparam logic [7:0] REG_SWEEP_STATUS      = 8'h24;

  localparam int STATUS_BUSY_BIT     = 0;
  localparam int STATUS_DONE_BIT     = 1;
  localparam int STATUS_OVERFLOW_BIT = 2;
  localparam int STATUS_TIMEOUT_BIT  = 3;

endpackage

// File: rtl/result_fifo.sv
// Synchronous first-word-fall-through FIFO.
//   clk, rst      : clock, asynchronous active-high reset
//   flush         : empties the FIFO (wins over push and pop)
//   push, wdata   : write request; refused when full unless a pop happens too
//   pop           : read strobe; ignored when empty
//   rdata, valid  : head entry, valid whenever the FIFO is not empty
//   full, count   : occupancy status
module result_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  // When full, a push is accepted only alongside a pop: the read of the
  // old head is combinational, so overwriting that slot at the edge is safe.
  always_comb begin
    pop_ok  = pop && (cnt_q != '0);
    push_ok = push && ((cnt_q != FULL_CNT) || pop_ok);
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_ok) wr_d = wr_q + AW'(1);
      if (pop_ok)  rd_d = rd_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt_d = cnt_q + (AW+1)'(1);
        2'b01:   cnt_d = cnt_q - (AW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem_q[wr_q] <= wdata;
  end

  assign rdata = mem_q[rd_q];
  assign valid = (cnt_q != '0);
  assign full  = (cnt_q == FULL_CNT);
  assign count = cnt_q;

endmodule

// File: rtl/ets_sweep_sequencer.sv
// ETS sweep sequencer: steps the clock-generator phase word across a
// programmed range, waits for settle + lock at each point, fires one sampler
// run and stores the 32-bit result in a FWFT result FIFO.
//   start/abort                       : one-cycle control pulses
//   phase_start/phase_step/step_count : sweep setup, latched on start
//   timing_control, clkgen_locked     : clock-generator interface
//   sampler_*                         : offset sampler interface
//   result_pop/data/valid/count       : result FIFO readback
//   busy, done, overflow, timeout     : status (last three sticky)
//   dbg_state                         : current sequencer state
//
// Handshakes: sampler_request_run is a single-cycle pulse; the sampler
// answers with sampler_running high, then a result is taken once
// sampler_running is low and sampler_result_ready is high. On the readback
// side result_data is valid whenever result_valid is high and an entry is
// consumed in each cycle where result_pop and result_valid are both high.
module ets_sweep_sequencer
  import picoview_pkg::*;
#(
  parameter int PHASE_WIDTH   = 32,
  parameter int RESULT_DEPTH  = 64,
  parameter int SETTLE_CYCLES = 1024,
  parameter int START_TIMEOUT = 255
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          abort,
  input  logic [PHASE_WIDTH-1:0]        phase_start,
  input  logic [PHASE_WIDTH-1:0]        phase_step,
  input  logic [15:0]                   step_count,
  output logic [PHASE_WIDTH-1:0]        timing_control,
  input  logic                          clkgen_locked,
  output logic                          sampler_request_run,
  input  logic                          sampler_running,
  input  logic                          sampler_result_ready,
  input  logic [31:0]                   sampler_result,
  input  logic                          result_pop,
  output logic [31:0]                   result_data,
  output logic                          result_valid,
  output logic [$clog2(RESULT_DEPTH):0] result_count,
  output logic                          busy,
  output logic                          done,
  output logic                          overflow,
  output logic                          timeout,
  output sweep_state_e                  dbg_state
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(START_TIMEOUT + 1);
  localparam logic [SW-1:0] SETTLE_LOAD  = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(START_TIMEOUT - 1);

  sweep_state_e           state_q, state_d;
  logic [PHASE_WIDTH-1:0] tc_q, tc_d;
  logic [PHASE_WIDTH-1:0] phase_q, phase_d;
  logic [PHASE_WIDTH-1:0] step_q, step_d;
  logic [15:0]            count_q, count_d;
  logic [15:0]            idx_q, idx_d;
  logic [SW-1:0]          settle_q, settle_d;
  logic [TW-1:0]          wait_q, wait_d;
  logic                   done_q, done_d;
  logic                   ovf_q, ovf_d;
  logic                   tmo_q, tmo_d;
  logic                   fifo_flush, fifo_push, fifo_full;

  // State register (plus datapath registers owned by the sequencer).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      tc_q     <= '0;
      phase_q  <= '0;
      step_q   <= '0;
      count_q  <= '0;
      idx_q    <= '0;
      settle_q <= '0;
      wait_q   <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tc_q     <= tc_d;
      phase_q  <= phase_d;
      step_q   <= step_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      settle_q <= settle_d;
      wait_q   <= wait_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      tmo_q    <= tmo_d;
    end
  end

  // Next-state and datapath updates. abort outranks everything else, and an
  // aborted STORE does not push its result.
  always_comb begin
    state_d    = state_q;
    tc_d       = tc_q;
    phase_d    = phase_q;
    step_d     = step_q;
    count_d    = count_q;
    idx_d      = idx_q;
    settle_d   = settle_q;
    wait_d     = wait_q;
    done_d     = done_q;
    ovf_d      = ovf_q;
    tmo_d      = tmo_q;
    fifo_flush = 1'b0;
    fifo_push  = 1'b0;
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            fifo_flush = 1'b1;
            done_d     = 1'b0;
            ovf_d      = 1'b0;
            tmo_d      = 1'b0;
            phase_d    = phase_start;
            step_d     = phase_step;
            count_d    = step_count;
            idx_d      = '0;
            state_d    = (step_count == 16'd0) ? ST_FINISH : ST_APPLY;
          end
        end
        ST_APPLY: begin
          tc_d     = phase_q;
          settle_d = SETTLE_LOAD;
          state_d  = ST_SETTLE;
        end
        ST_SETTLE: begin
          // Counter parks at zero; lock loss holds here indefinitely.
          if (settle_q == '0) begin
            if (clkgen_locked) state_d = ST_TRIGGER;
          end else begin
            settle_d = settle_q - SW'(1);
          end
        end
        ST_TRIGGER: begin
          wait_d  = '0;
          state_d = ST_WAIT_START;
        end
        ST_WAIT_START: begin
          if (sampler_running) begin
            state_d = ST_WAIT_DONE;
          end else if (wait_q == TIMEOUT_LAST) begin
            tmo_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            wait_d = wait_q + TW'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (!sampler_running && sampler_result_ready) state_d = ST_STORE;
        end
        ST_STORE: begin
          fifo_push = 1'b1;
          if (fifo_full && !result_pop) ovf_d = 1'b1;
          idx_d   = idx_q + 16'd1;
          phase_d = phase_q + step_q;
          state_d = (idx_q + 16'd1 == count_q) ? ST_FINISH : ST_APPLY;
        end
        ST_FINISH: begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs decoded from the current state.
  always_comb begin
    sampler_request_run = (state_q == ST_TRIGGER);
    busy                = (state_q != ST_IDLE);
    dbg_state           = state_q;
  end

  assign timing_control = tc_q;
  assign done           = done_q;
  assign overflow       = ovf_q;
  assign timeout        = tmo_q;

  result_fifo #(
    .WIDTH (32),
    .DEPTH (RESULT_DEPTH)
  ) u_result_fifo (
    .clk   (clk),
    .rst   (reset),
    .flush (fifo_flush),
    .push  (fifo_push),
    .wdata (sampler_result),
    .pop   (result_pop),
    .rdata (result_data),
    .valid (result_valid),
    .full  (fifo_full),
    .count (result_count)
  );

endmodule
